// File: rtl/pulse_merger.sv
// pulse_merger
//   Merges two pulse sources into one pulse stream that drives a downstream
//   T flip-flop. Consecutive output pulses are at least SEP_CYCLES clocks apart.
//   Pulses that arrive too early wait in a saturating pending counter. Pulses
//   beyond PEND_MAX are dropped, counted and flagged.
//
//   Handshake: this block has no valid/ready pair. Each 0->1 sample of in_a or
//   in_b is one event. Each event is either issued on out (one cycle high),
//   held in pend, or counted in drop_cnt. It is never back-pressured.
//
// Ports
//   clk       rising-edge clock
//   sep_clr   asynchronous active-high reset
//   in_a      pulse source A (synchronous level, rising sample = event)
//   in_b      pulse source B (same rules as in_a)
//   out       merged pulse, one cycle high per issued pulse
//   busy      high while in the separation gap or while pulses are pending
//   pend      number of pulses currently queued
//   overflow  sticky, set when any event is dropped
//   drop_cnt  dropped events, saturating at 255
module pulse_merger #(
    parameter int SEP_CYCLES = 10,
    parameter int PEND_MAX   = 7,
    localparam int PW        = $clog2(PEND_MAX + 1),
    localparam int GW        = $clog2(SEP_CYCLES)
) (
    input  logic          clk,
    input  logic          sep_clr,
    input  logic          in_a,
    input  logic          in_b,
    output logic          out,
    output logic          busy,
    output logic [PW-1:0] pend,
    output logic          overflow,
    output logic [7:0]    drop_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    localparam logic [PW+1:0] PMAX     = (PW + 2)'(PEND_MAX);
    localparam logic [GW-1:0] GAP_LOAD = GW'(SEP_CYCLES - 1);

    // Kept as a named register so checkers can bind to the FSM state.
    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic          prev_a;
    logic          prev_b;

    logic          ev_a;
    logic          ev_b;
    logic [1:0]    ev;
    logic          can_fire;
    logic [PW+1:0] avail;
    logic          fire;
    logic [PW+1:0] total;
    logic          clamp;
    logic [PW+1:0] excess;
    logic [8:0]    drop_sum;
    logic [7:0]    drop_next;

    always_comb begin
        ev_a      = in_a & ~prev_a;
        ev_b      = in_b & ~prev_b;
        ev        = {1'b0, ev_a} + {1'b0, ev_b};
        // A GAP with an expired counter behaves exactly like IDLE.
        can_fire  = (state == IDLE) || (gap_cnt == '0);
        avail     = {2'b00, pend} + {{PW{1'b0}}, ev};
        fire      = can_fire && (avail != '0);
        // The fire is subtracted before the capacity clamp.
        total     = avail - {{(PW+1){1'b0}}, fire};
        clamp     = (total > PMAX);
        excess    = clamp ? (total - PMAX) : '0;
        // At most two events arrive per edge, so the excess fits in 2 bits.
        drop_sum  = {1'b0, drop_cnt} + {7'b0, excess[1:0]};
        drop_next = drop_sum[8] ? 8'hff : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge sep_clr) begin
        if (sep_clr) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            out      <= 1'b0;
            pend     <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            // Reset high so an input held high through release is not an event.
            prev_a   <= 1'b1;
            prev_b   <= 1'b1;
        end else begin
            prev_a <= in_a;
            prev_b <= in_b;

            if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
                out     <= 1'b0;
            end else if (fire) begin
                out     <= 1'b1;
                gap_cnt <= GAP_LOAD;
                state   <= GAP;
            end else begin
                out   <= 1'b0;
                state <= IDLE;
            end

            if (clamp) begin
                pend     <= PMAX[PW-1:0];
                overflow <= 1'b1;
                drop_cnt <= drop_next;
            end else begin
                pend <= total[PW-1:0];
            end
        end
    end

    assign busy = (state == GAP) || (pend != '0);

endmodule

// File: tb/tb_pulse_merger.sv
// tb_pulse_merger
//   Directed and randomized stimulus for pulse_merger. The reference model
//   tracks the time of the last issued pulse and a pending count, so a pulse
//   may issue whenever SEP_CYCLES edges have passed since the previous one.
module tb_pulse_merger;

    localparam int SEP  = 10;
    localparam int PMAX = 7;
    localparam int PW   = $clog2(PMAX + 1);

    logic          clk = 1'b0;
    logic          sep_clr = 1'b0;
    logic          in_a = 1'b0;
    logic          in_b = 1'b0;
    logic          out;
    logic          busy;
    logic [PW-1:0] pend;
    logic          overflow;
    logic [7:0]    drop_cnt;

    pulse_merger #(.SEP_CYCLES(SEP), .PEND_MAX(PMAX)) dut (
        .clk      (clk),
        .sep_clr  (sep_clr),
        .in_a     (in_a),
        .in_b     (in_b),
        .out      (out),
        .busy     (busy),
        .pend     (pend),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    int m_edge, m_last, m_pend, m_drops, m_dcnt;
    bit m_ovf, m_out, m_busy, m_pa, m_pb;
    int m_events;
    // downstream T flip-flop observer
    int t_last_rise, t_issued;
    bit t_q;
    int max_pend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_edge = 0; m_last = -1000; m_pend = 0; m_drops = 0; m_dcnt = 0;
        m_ovf = 0; m_out = 0; m_busy = 0; m_pa = 1; m_pb = 1;
        m_events = 0; t_last_rise = -1000; t_issued = 0; t_q = 0;
    endtask

    task automatic model_edge(input bit a, input bit b);
        int ev, tot, drop;
        bit fire;
        ev = int'(a && !m_pa) + int'(b && !m_pb);
        m_pa = a; m_pb = b;
        m_edge++;
        m_events += ev;
        fire = (m_edge - m_last >= SEP) && (m_pend + ev > 0);
        if (fire) m_last = m_edge;
        tot = m_pend + ev - int'(fire);
        if (tot > PMAX) begin
            drop = tot - PMAX;
            m_drops += drop;
            m_dcnt = (m_dcnt + drop > 255) ? 255 : m_dcnt + drop;
            m_ovf = 1;
            m_pend = PMAX;
        end else begin
            m_pend = tot;
        end
        m_out  = fire;
        m_busy = (m_pend > 0) || (m_edge - m_last < SEP);
    endtask

    task automatic check_outputs();
        check("out", out, m_out);
        check("pend", pend, m_pend);
        check("busy", busy, m_busy);
        check("overflow", overflow, m_ovf);
        check("drop_cnt", drop_cnt, m_dcnt);
        if (out === 1'b1) begin
            check("t_separation", (m_edge - t_last_rise >= SEP), 1);
            t_last_rise = m_edge;
            t_issued++;
            t_q = ~t_q;
        end
        if (int'(pend) > max_pend) max_pend = int'(pend);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit a, input bit b);
        in_a = a; in_b = b;
        @(posedge clk);
        #1;
        model_edge(a, b);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    // Asserted between edges; outputs must clear without any clock edge.
    task automatic async_reset(input bit hold_a);
        sep_clr = 1'b1;
        #1;
        check("rst_out", out, 0);
        check("rst_pend", pend, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        in_a = hold_a; in_b = 1'b0;
        #1;
        sep_clr = 1'b0;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int found, rate;
        model_reset();
        max_pend = 0;

        // Power-up reset with in_a held high through release.
        async_reset(1'b1);
        step(1, 0);
        check("held_high_no_event", out, 0);
        step(1, 0);
        idle(2);

        // Single pulse: issued on the sampling edge.
        step(1, 0);
        check("single_out", out, 1);
        check("single_busy", busy, 1);
        idle(SEP - 1);
        check("single_busy_gap_end", busy, 1);
        idle(1);
        check("single_busy_low", busy, 0);
        idle(3);

        // Simultaneous A and B: two pulses SEP apart.
        step(1, 1);
        check("simul_first_out", out, 1);
        check("simul_pend1", pend, 1);
        idle(SEP - 1);
        check("simul_gap_out", out, 0);
        idle(1);
        check("simul_second_out", out, 1);
        check("simul_pend0", pend, 0);
        idle(SEP + 2);

        // Burst of four A events on alternate edges.
        max_pend = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 0);
            step(0, 0);
        end
        idle(4 * SEP);
        check("burst_peak_pend", max_pend, 3);
        check("burst_no_overflow", overflow, 0);

        // Overflow: one fire, then four event pairs inside the same gap.
        step(1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0);
            step(1, 1);
        end
        check("ovf_pend", pend, PMAX);
        check("ovf_flag", overflow, 1);
        check("ovf_drop_cnt", drop_cnt, 1);

        // Continued burst drives drop_cnt into saturation.
        for (int i = 0; i < 300; i++) begin
            step(0, 0);
            step(1, 1);
        end
        check("sat_drop_cnt", drop_cnt, 255);
        check("sat_overflow", overflow, 1);

        // Drain until a pulse issues with three still pending, then reset.
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            step(0, 0);
            if (out === 1'b1 && pend === PW'(3)) found = 1;
        end
        check("reach_pend3_out1", found, 1);
        async_reset(1'b1);
        step(1, 0);
        check("post_rst_no_event", out, 0);
        idle(2);
        step(1, 0);
        check("post_rst_fire", out, 1);
        idle(SEP + 1);

        // Randomized run observed by the downstream T stage.
        async_reset(1'b0);
        for (int blk = 0; blk < 20; blk++) begin
            rate = $urandom_range(1, 12);
            for (int i = 0; i < 1000; i++)
                step($urandom_range(0, 99) < rate, $urandom_range(0, 99) < rate);
        end
        check("conservation_total", t_issued + int'(pend) + m_drops, m_events);
        if (m_drops <= 255)
            check("conservation_drop_cnt", t_issued + int'(pend) + int'(drop_cnt), m_events);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
